// File: rtl/ccd_seq_pkg.sv
// ccd_seq_pkg: shared FSM state codes, default frame timing and a width helper
// for the CCD frame sequencer.
package ccd_seq_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FLUSH   = 3'd1;
    localparam logic [2:0] S_SHUTTER = 3'd2;
    localparam logic [2:0] S_XFER    = 3'd3;
    localparam logic [2:0] S_VSHIFT  = 3'd4;
    localparam logic [2:0] S_HREAD   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int DEF_H_TOTAL     = 1560;
    localparam int DEF_ACT_START   = 40;
    localparam int DEF_ACT_LEN     = 1500;
    localparam int DEF_CLPOB_START = 8;
    localparam int DEF_CLPOB_LEN   = 20;
    localparam int DEF_V_PW        = 24;
    localparam int DEF_SG_PW       = 48;
    localparam int DEF_V_LINES     = 1000;
`ifdef SEQ_FLUSH_EN
    localparam int DEF_FLUSH_LINES = 1020;
`endif

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/ccd_hline_timer.sv
// ccd_hline_timer: horizontal pixel counter for one HREAD line with registered
// AFE window strobes (HD, CLPOB, PBLK) and the pixel qualifier.
module ccd_hline_timer #(
    parameter int H_TOTAL     = 1560,
    parameter int ACT_START   = 40,
    parameter int ACT_LEN     = 1500,
    parameter int CLPOB_START = 8,
    parameter int CLPOB_LEN   = 20,
    parameter int HW          = 11
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_last,
    output logic o_hd,
    output logic o_clpob,
    output logic o_pblk,
    output logic o_pix_valid
);
    logic [HW-1:0] r_h;
    logic [HW-1:0] w_h_n;
    logic          w_act;
    logic          w_clp;

    // Strobes are decoded from the h value of the coming cycle so they line up with it.
    assign w_h_n  = i_clear ? '0 : r_h + HW'(1);
    assign w_act  = w_h_n >= HW'(ACT_START) && w_h_n < HW'(ACT_START + ACT_LEN);
    assign w_clp  = w_h_n >= HW'(CLPOB_START) && w_h_n < HW'(CLPOB_START + CLPOB_LEN);
    assign o_last = r_h == HW'(H_TOTAL - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h         <= '0;
            o_hd        <= 1'b1;
            o_clpob     <= 1'b1;
            o_pblk      <= 1'b1;
            o_pix_valid <= 1'b0;
        end else begin
            r_h         <= i_run ? w_h_n : '0;
            o_hd        <= !(i_run && w_h_n == '0);
            o_clpob     <= !(i_run && w_clp);
            o_pblk      <= !i_run || w_act;
            o_pix_valid <= i_run && w_act;
        end
    end
endmodule

// File: rtl/ccd_frame_sequencer.sv
// ccd_frame_sequencer: one-shot CCD/AFE frame timing (shutter, transfer, line readout).
// Define SEQ_FLUSH_EN to add a vertical charge flush before exposure.
module ccd_frame_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int ACT_START   = DEF_ACT_START,
    parameter int ACT_LEN     = DEF_ACT_LEN,
    parameter int CLPOB_START = DEF_CLPOB_START,
    parameter int CLPOB_LEN   = DEF_CLPOB_LEN,
    parameter int V_PW        = DEF_V_PW,
    parameter int SG_PW       = DEF_SG_PW,
`ifdef SEQ_FLUSH_EN
    parameter int FLUSH_LINES = DEF_FLUSH_LINES,
`endif
    parameter int V_LINES     = DEF_V_LINES
) (
    input  logic        CLK_24M,
    input  logic        CPU_RST,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] exp_cycles,
    output logic        ccd_nxv1,
    output logic        ccd_nxv2,
    output logic        ccd_nxsg2,
    output logic        ccd_shut,
    output logic        afe_vd,
    output logic        afe_hd,
    output logic        afe_pblk,
    output logic        afe_clpob,
    output logic        pix_valid,
    output logic        line_valid,
    output logic        busy,
    output logic        frame_done
);
    localparam int XFER_LEN = SG_PW + 2 * V_PW;
    localparam int VS_LEN   = 2 * V_PW;
`ifdef SEQ_FLUSH_EN
    localparam int MAXP = imax(imax(imax(H_TOTAL, XFER_LEN), V_LINES), FLUSH_LINES);
`else
    localparam int MAXP = imax(imax(H_TOTAL, XFER_LEN), V_LINES);
`endif
    localparam int CW = $clog2(MAXP + 1);

    logic [2:0]    r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [CW-1:0] r_line, w_line_n;
    logic [31:0]   r_exp, w_exp_n;
    logic          w_last, w_vs, w_xfer;
`ifdef SEQ_FLUSH_EN
    logic [CW-1:0] r_flush, w_flush_n;
    assign w_vs = w_state_n == S_VSHIFT || w_state_n == S_FLUSH;
`else
    assign w_vs = w_state_n == S_VSHIFT;
`endif
    assign w_xfer = w_state_n == S_XFER;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = '0;
        w_line_n  = r_line;
        w_exp_n   = r_exp;
`ifdef SEQ_FLUSH_EN
        w_flush_n = r_flush;
`endif
        // Abort wins over any end-of-state transition on the same clock.
        if (abort && r_state != S_IDLE) begin
            w_state_n = S_IDLE;
`ifdef SEQ_FLUSH_EN
            w_flush_n = '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    w_exp_n = exp_cycles;
`ifdef SEQ_FLUSH_EN
                    w_state_n = S_FLUSH;
`else
                    w_state_n = exp_cycles == '0 ? S_XFER : S_SHUTTER;
`endif
                end
`ifdef SEQ_FLUSH_EN
                S_FLUSH: if (r_cnt == CW'(VS_LEN - 1)) begin
                    w_flush_n = r_flush == CW'(FLUSH_LINES - 1) ? '0 : r_flush + CW'(1);
                    if (r_flush == CW'(FLUSH_LINES - 1))
                        w_state_n = r_exp == '0 ? S_XFER : S_SHUTTER;
                end else
                    w_cnt_n = r_cnt + CW'(1);
`endif
                S_SHUTTER: begin
                    w_exp_n = r_exp - 32'(r_exp != '0);
                    if (r_exp <= 32'd1) w_state_n = S_XFER;
                end
                S_XFER: begin
                    w_line_n = '0;
                    if (r_cnt == CW'(XFER_LEN - 1)) w_state_n = S_VSHIFT;
                    else w_cnt_n = r_cnt + CW'(1);
                end
                S_VSHIFT: if (r_cnt == CW'(VS_LEN - 1)) w_state_n = S_HREAD;
                    else w_cnt_n = r_cnt + CW'(1);
                S_HREAD: if (w_last) begin
                    w_line_n  = r_line + CW'(1);
                    w_state_n = r_line == CW'(V_LINES - 1) ? S_DONE : S_VSHIFT;
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    ccd_hline_timer #(
        .H_TOTAL(H_TOTAL), .ACT_START(ACT_START), .ACT_LEN(ACT_LEN),
        .CLPOB_START(CLPOB_START), .CLPOB_LEN(CLPOB_LEN), .HW(CW)
    ) u_hline (
        .i_clk(CLK_24M), .i_rst(CPU_RST),
        .i_run(w_state_n == S_HREAD), .i_clear(r_state != S_HREAD),
        .o_last(w_last), .o_hd(afe_hd), .o_clpob(afe_clpob),
        .o_pblk(afe_pblk), .o_pix_valid(pix_valid)
    );

    // Outputs decode the next state so each strobe coincides with its state cycle.
    always_ff @(posedge CLK_24M or posedge CPU_RST) begin
        if (CPU_RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_line     <= '0;
            r_exp      <= '0;
            ccd_nxv1   <= 1'b1;
            ccd_nxv2   <= 1'b1;
            ccd_nxsg2  <= 1'b1;
            ccd_shut   <= 1'b0;
            afe_vd     <= 1'b1;
            line_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_line     <= w_line_n;
            r_exp      <= w_exp_n;
            ccd_nxv1   <= !(w_xfer || (w_vs && w_cnt_n < CW'(V_PW)));
            ccd_nxv2   <= !(w_vs && w_cnt_n >= CW'(V_PW));
            ccd_nxsg2  <= !(w_xfer && w_cnt_n >= CW'(V_PW) && w_cnt_n < CW'(V_PW + SG_PW));
            ccd_shut   <= w_state_n == S_SHUTTER;
            afe_vd     <= !(w_xfer && w_cnt_n == '0);
            line_valid <= w_state_n == S_HREAD;
            busy       <= w_state_n != S_IDLE;
            frame_done <= w_state_n == S_DONE;
        end
    end
`ifdef SEQ_FLUSH_EN
    always_ff @(posedge CLK_24M or posedge CPU_RST) begin
        if (CPU_RST) r_flush <= '0;
        else r_flush <= w_flush_n;
    end
`endif
endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// tb_ccd_frame_sequencer: random frames against an expected per-cycle waveform
// built from the frame timing rules.
module tb_ccd_frame_sequencer;
    localparam int H    = 16;
    localparam int AS   = 4;
    localparam int AL   = 8;
    localparam int CS   = 12;
    localparam int CL   = 2;
    localparam int VPW  = 2;
    localparam int SGPW = 3;
    localparam int VL   = 3;
    localparam int T    = SGPW + 2 * VPW;
`ifdef SEQ_FLUSH_EN
    localparam int FL   = 4;
    localparam int FLC  = FL * 2 * VPW;
`else
    localparam int FLC  = 0;
`endif
    localparam logic [11:0] IDLE = 12'b1110_1111_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] exp_cycles = '0;
    logic nxv1, nxv2, nxsg2, shut, vd, hd, pblk, clpob, pv, lv, busy, done;
    logic [11:0] w_obs;
    logic [11:0] q[$];
    int n_cmp = 0;
    int n_err = 0;

    assign w_obs = {nxv1, nxv2, nxsg2, shut, vd, hd, pblk, clpob, pv, lv, busy, done};

    always #5 clk = ~clk;

    ccd_frame_sequencer #(
        .H_TOTAL(H), .ACT_START(AS), .ACT_LEN(AL), .CLPOB_START(CS), .CLPOB_LEN(CL),
        .V_PW(VPW), .SG_PW(SGPW),
`ifdef SEQ_FLUSH_EN
        .FLUSH_LINES(FL),
`endif
        .V_LINES(VL)
    ) dut (
        .CLK_24M(clk), .CPU_RST(rst), .start(start), .abort(abort), .exp_cycles(exp_cycles),
        .ccd_nxv1(nxv1), .ccd_nxv2(nxv2), .ccd_nxsg2(nxsg2), .ccd_shut(shut),
        .afe_vd(vd), .afe_hd(hd), .afe_pblk(pblk), .afe_clpob(clpob),
        .pix_valid(pv), .line_valid(lv), .busy(busy), .frame_done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int flen(input int e);
        return FLC + e + T + VL * (2 * VPW + H) + 1;
    endfunction

    // Expected outputs {nxv1,nxv2,nxsg2,shut,vd,hd,pblk,clpob,pix,line,busy,done} per frame cycle.
    task automatic build(input int e);
        q.delete();
`ifdef SEQ_FLUSH_EN
        for (int f = 0; f < FL; f++)
            for (int c = 0; c < 2 * VPW; c++)
                q.push_back({c >= VPW, c < VPW, 1'b1, 1'b0, 4'b1111, 2'b00, 2'b10});
`endif
        repeat (e) q.push_back({3'b111, 1'b1, 4'b1111, 2'b00, 2'b10});
        for (int c = 0; c < T; c++)
            q.push_back({1'b0, 1'b1, !(c >= VPW && c < VPW + SGPW), 1'b0, c != 0, 3'b111, 2'b00, 2'b10});
        for (int l = 0; l < VL; l++) begin
            for (int c = 0; c < 2 * VPW; c++)
                q.push_back({c >= VPW, c < VPW, 1'b1, 1'b0, 4'b1111, 2'b00, 2'b10});
            for (int h = 0; h < H; h++) begin
                logic act;
                act = h >= AS && h < AS + AL;
                q.push_back({3'b111, 1'b0, 1'b1, h != 0, act, !(h >= CS && h < CS + CL), act, 1'b1, 2'b10});
            end
        end
        q.push_back({3'b111, 1'b0, 4'b1111, 2'b00, 2'b11});
    endtask

    task automatic run_frame(input int e, input int ab, input int spur);
        int npv = 0, nhd = 0, ndone = 0, nsh = 0;
        build(e);
        exp_cycles = e;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            chk("frame", w_obs, q[i]);
            chk("v_overlap", 32'(!nxv1 && !nxv2), 0);
            npv += pv;
            nhd += !hd;
            ndone += done;
            nsh += shut;
            exp_cycles = $urandom;
            start = i == spur;
            abort = i == ab;
            tick;
            start = 1'b0;
            abort = 1'b0;
            if (i == ab) begin
                chk("abort", w_obs, IDLE);
                tick;
                chk("abort_idle", w_obs, IDLE);
                return;
            end
        end
        chk("post_frame", w_obs, IDLE);
        chk("pix_count", npv, VL * AL);
        chk("hd_count", nhd, VL);
        chk("done_count", ndone, 1);
        chk("shut_count", nsh, e);
    endtask

    initial begin
        repeat (3) tick;
        chk("reset", w_obs, IDLE);
        rst = 1'b0;
        tick;
        chk("idle", w_obs, IDLE);
        run_frame(5, -1, 10);
        run_frame(0, -1, 3);
        run_frame(3, FLC + 3 + T + (2 * VPW + H) + 2 * VPW + 5, -1);
        run_frame(2, -1, -1);
        run_frame(1, FLC + 1 + T - 1, -1);
        run_frame(4, flen(4) - 2, -1);
        run_frame(0, -1, -1);
        repeat (8) begin
            int e, ab;
            e = $urandom_range(0, 8);
            ab = $urandom_range(0, 2) == 0 ? $urandom_range(0, flen(e) - 2) : -1;
            run_frame(e, ab, $urandom_range(1, flen(e) - 2));
        end
        exp_cycles = 1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 200 && !lv; i++) tick;
        chk("reach_hread", lv, 1);
        #2 rst = 1'b1;
        #1 chk("async_reset", w_obs, IDLE);
        @(negedge clk) rst = 1'b0;
        tick;
        chk("post_reset_busy", busy, 0);
        chk("post_reset", w_obs, IDLE);
        run_frame(2, -1, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
